// File: rtl/nibble_addsub.sv
// rtl/nibble_addsub.sv - multi-cycle WIDTH-bit adder/subtractor, one nibble per clock
module nibble_addsub #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NIBS = WIDTH / 4;
  localparam int IW   = $clog2(NIBS);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state;
  state_t           state_n;

  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] part;
  logic [WIDTH-1:0] part_n;
  logic [IW-1:0]    idx;
  logic             carry;

  logic [IW+1:0]    base;
  logic [3:0]       nib_a;
  logic [3:0]       nib_b;
  logic [3:0]       p;
  logic [3:0]       g;
  logic [3:0]       c;
  logic [3:0]       sum_nib;
  logic             last;

  // Slice out the current nibble and form the lookahead carries and sum bits.
  // Carries are the two-level AND-OR form, so nothing ripples inside a cycle.
  always_comb begin
    base    = {idx, 2'b00};
    nib_a   = op_a[base +: 4];
    nib_b   = op_b[base +: 4];
    p       = nib_a ^ nib_b;
    g       = nib_a & nib_b;
    c[0]    = g[0] | (p[0] & carry);
    c[1]    = g[1] | (p[1] & g[0]) | (p[1] & p[0] & carry);
    c[2]    = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
            | (p[2] & p[1] & p[0] & carry);
    c[3]    = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
            | (p[3] & p[2] & p[1] & g[0])
            | (p[3] & p[2] & p[1] & p[0] & carry);
    sum_nib = p ^ {c[2:0], carry};
    part_n  = part;
    part_n[base +: 4] = sum_nib;
    last    = (idx == IW'(NIBS - 1));
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next state: start is honoured only from IDLE; RUN ends after the top nibble.
  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (start) state_n = RUN;
      RUN:  if (last)  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Operand capture and per-nibble accumulation. Subtraction is a + ~b + 1,
  // so b is inverted on capture and the carry is seeded with sub.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_a  <= '0;
      op_b  <= '0;
      part  <= '0;
      idx   <= '0;
      carry <= 1'b0;
    end else if (state == IDLE) begin
      if (start) begin
        op_a  <= a;
        op_b  <= sub ? ~b : b;
        part  <= '0;
        idx   <= '0;
        carry <= sub;
      end
    end else begin
      part  <= part_n;
      carry <= c[3];
      idx   <= last ? '0 : idx + IW'(1);
    end
  end

  // Result registers: updated only on the completion edge, held otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      done <= 1'b0;
      sum  <= '0;
      cout <= 1'b0;
      ovf  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == RUN && last) begin
        done <= 1'b1;
        sum  <= part_n;
        cout <= c[3];
        ovf  <= c[3] ^ c[2];
      end
    end
  end

  assign busy = (state == RUN);

endmodule
